// File: rtl/sys_pkg.sv
// Shared types, defaults and result formatting for the multi-lane systolic PE.
package sys_pkg;

    localparam int WL_DEF    = 32;
    localparam int FRAC_DEF  = 16;
    localparam int LANES_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Arithmetic shift down by frac, then clamp to a signed wl-bit range (wl <= 64).
    function automatic logic signed [63:0] sat_shift(input logic signed [127:0] acc,
                                                     input int frac, input int wl);
        logic signed [127:0] sh;
        logic signed [127:0] mx;
        logic signed [127:0] mn;
        sh = acc >>> frac;
        mx = (128'sd1 <<< (wl - 1)) - 128'sd1;
        mn = -mx - 128'sd1;
        if (sh > mx)
            sat_shift = mx[63:0];
        else if (sh < mn)
            sat_shift = mn[63:0];
        else
            sat_shift = sh[63:0];
    endfunction

endpackage

// File: rtl/sys_pe_mlane_if.sv
// Result-chain link between neighbouring PEs.
interface sys_pe_mlane_if
    import sys_pkg::*;
#(
    parameter int WL = WL_DEF
);
    // A word moves on every edge where valid && ready; the sender keeps value and valid stable until then.
    logic [WL-1:0] value;
    logic          valid;
    logic          ready;

    modport master (output value, output valid, input ready);
    modport slave  (input value, input valid, output ready);
endinterface

// File: rtl/sys_res_chain.sv
// Result chain: output register, one pending slot for own results, arbitration and overflow flag.
module sys_res_chain
    import sys_pkg::*;
#(
    parameter int WL = WL_DEF
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic           own_fin,
    input  logic [WL-1:0]  own_value,
    sys_pe_mlane_if.slave  res_in,
    sys_pe_mlane_if.master result,
    output logic           ovf
);

    logic          out_valid;
    logic [WL-1:0] out_data;
    logic          pend_valid;
    logic [WL-1:0] pend_data;
    logic          out_free;

    always_comb begin
        out_free     = !out_valid || result.ready;
        res_in.ready = rst && ena && !pend_valid && out_free && !own_fin;
    end

    assign result.valid = out_valid;
    assign result.value = out_data;

    // Own pending result beats a freshly finalised one, which beats upstream traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            ovf        <= 1'b0;
        end else if (ena) begin
            if (out_free) begin
                if (pend_valid) begin
                    out_data   <= pend_data;
                    out_valid  <= 1'b1;
                    pend_valid <= own_fin;
                    if (own_fin)
                        pend_data <= own_value;
                end else if (own_fin) begin
                    out_data  <= own_value;
                    out_valid <= 1'b1;
                end else if (res_in.valid && res_in.ready) begin
                    out_data  <= res_in.value;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (own_fin) begin
                if (!pend_valid) begin
                    pend_data  <= own_value;
                    pend_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sys_pe_mlane.sv
// Multi-lane systolic PE: forwards operands, accumulates LANES-wide dot products per tile,
// and drains formatted tile results over the result chain.
module sys_pe_mlane
    import sys_pkg::*;
#(
    parameter int WL     = WL_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ACC_WL = 2 * WL + 8
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                relu_en,
    input  logic [LANES*WL-1:0] weightvalue,
    input  logic                weigthvalid,
    input  logic                weigthend,
    input  logic [LANES*WL-1:0] featurevalue,
    input  logic                featurevalid,
    input  logic                featureend,
    output logic [LANES*WL-1:0] weightoutvalue,
    output logic                weigthoutvalid,
    output logic                weigthoutend,
    output logic [LANES*WL-1:0] featureoutvalue,
    output logic                featureoutvalid,
    output logic                featureoutend,
    sys_pe_mlane_if.slave       res_in,
    sys_pe_mlane_if.master      result,
    output logic                ovf,
    output logic                proto_err,
    output state_t              state
);

    logic                    relu_q;
    logic                    fire_q;
    logic                    end_q;
    logic signed [2*WL-1:0]  prod_d [LANES];
    logic signed [2*WL-1:0]  prod_q [LANES];
    logic                    s1_valid;
    logic                    s1_end;
    logic                    relu_s1;
    logic signed [ACC_WL-1:0] acc;
    logic signed [ACC_WL-1:0] lane_sum;
    logic signed [ACC_WL-1:0] sum_next;
    logic                    relu_lat;
    logic                    relu_eff;
    logic                    own_fin;
    logic [WL-1:0]           own_raw;
    logic [WL-1:0]           own_value;
    state_t                  state_nx;

    // The forwarding registers double as the operand input stage of the multiply pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weightoutvalue  <= '0;
            weigthoutvalid  <= 1'b0;
            weigthoutend    <= 1'b0;
            featureoutvalue <= '0;
            featureoutvalid <= 1'b0;
            featureoutend   <= 1'b0;
            relu_q          <= 1'b0;
            proto_err       <= 1'b0;
        end else if (ena) begin
            weightoutvalue  <= weightvalue;
            weigthoutvalid  <= weigthvalid;
            weigthoutend    <= weigthend;
            featureoutvalue <= featurevalue;
            featureoutvalid <= featurevalid;
            featureoutend   <= featureend;
            relu_q          <= relu_en;
            if (weigthvalid && featurevalid && (weigthend != featureend))
                proto_err <= 1'b1;
        end
    end

    assign fire_q = weigthoutvalid && featureoutvalid;
    assign end_q  = weigthoutend || featureoutend;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = $signed({{WL{weightoutvalue[i*WL+WL-1]}}, weightoutvalue[i*WL +: WL]})
                      * $signed({{WL{featureoutvalue[i*WL+WL-1]}}, featureoutvalue[i*WL +: WL]});
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + ACC_WL'(prod_q[i]);
        sum_next  = acc + lane_sum;
        own_raw   = WL'(sat_shift(128'(sum_next), FRAC, WL));
        own_value = (relu_eff && own_raw[WL-1]) ? '0 : own_raw;
    end

    // The accumulator clears on the end pair itself, so the next tile can follow immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '{default: '0};
            s1_valid <= 1'b0;
            s1_end   <= 1'b0;
            relu_s1  <= 1'b0;
            acc      <= '0;
            relu_lat <= 1'b0;
        end else if (ena) begin
            prod_q   <= prod_d;
            s1_valid <= fire_q;
            s1_end   <= end_q;
            relu_s1  <= relu_q;
            if (s1_valid) begin
                acc <= s1_end ? '0 : sum_next;
                if (state == IDLE)
                    relu_lat <= relu_s1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (ena)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (s1_valid) state_nx = s1_end ? IDLE : ACC;
            ACC:     if (s1_valid && s1_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // relu_en travels with the first pair; later pairs of the tile use the latched copy.
    always_comb begin
        own_fin  = ena && s1_valid && s1_end;
        relu_eff = (state == IDLE) ? relu_s1 : relu_lat;
    end

    sys_res_chain #(.WL(WL)) u_chain (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .own_fin   (own_fin),
        .own_value (own_value),
        .res_in    (res_in),
        .result    (result),
        .ovf       (ovf)
    );

endmodule
